// File: rtl/sd_pkg.sv
// Shared types, constants and CRC7 helper for the SD SPI-mode command sequencer.
package sd_pkg;

  typedef enum logic [3:0] {
    ST_BOOT,
    ST_IDLE,
    ST_PRE,
    ST_CMD,
    ST_R1,
    ST_TOKEN,
    ST_DATA,
    ST_CRC,
    ST_TAIL
  } sd_state_e;

  localparam logic [2:0] SD_ERR_OK            = 3'd0;
  localparam logic [2:0] SD_ERR_R1_TIMEOUT    = 3'd1;
  localparam logic [2:0] SD_ERR_R1            = 3'd2;
  localparam logic [2:0] SD_ERR_TOKEN_TIMEOUT = 3'd3;
  localparam logic [2:0] SD_ERR_TOKEN         = 3'd4;
  localparam logic [2:0] SD_ERR_CRC           = 3'd5;

  localparam logic [7:0] SD_TOKEN_START = 8'hFE;
  localparam logic [7:0] SD_FILL        = 8'hFF;

  // CRC7 (x^7+x^3+1), one byte MSB first.
  function automatic logic [6:0] sd_crc7_byte(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic [7:0] d;
    logic       fb;
    c = crc;
    d = data;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[6] ^ d[7];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
      d  = {d[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/sd_crc16.sv
// Byte-serial CRC-CCITT (x^16+x^12+x^5+1, init 0) accumulator with clear and enable.
module sd_crc16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    logic [15:0] c;
    logic [7:0]  d;
    logic        fb;
    c = crc_q;
    d = din;
    for (int unsigned i = 0; i < 8; i++) begin
      fb = c[15] ^ d[7];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
      d  = {d[6:0], 1'b0};
    end
    crc_d = crc_q;
    if (clr)     crc_d = '0;
    else if (en) crc_d = c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_sequencer.sv
// SD SPI-mode transaction sequencer: command framing, R1 poll, optional block read.
// Optional data CRC16 check is built when SD_CRC16_CHECK_EN is defined.
module sd_cmd_sequencer
  import sd_pkg::*;
#(
  parameter int unsigned NCR_MAX       = 8,
  parameter int unsigned TOKEN_TIMEOUT = 4096,
  parameter int unsigned BLOCK_LEN     = 512
) (
  input  logic        CLOCK_50,
  input  logic        nRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic        cmd_rd_block,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  input  logic        spi_busy,
  input  logic [7:0]  spi_rx,
  output logic        spi_cs_n,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic [7:0]  r1,
  output logic [2:0]  err
);

  sd_state_e   state_q, state_d;
  logic        pend_q, pend_d;
  logic        busy_q;
  logic        cs_n_q, cs_n_d;
  logic [7:0]  r1_q, r1_d;
  logic [2:0]  err_q, err_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic        rd_q, rd_d;
  logic [6:0]  crc7_q, crc7_d;
  logic [12:0] poll_q, poll_d;
  logic [15:0] cnt_q, cnt_d;

  logic        xfer_done;
  logic        want_byte;
  logic        issue;
  logic        to_tail;
  logic [7:0]  tx_byte;
  logic [12:0] poll_inc;

  // A transfer completes only on a falling busy edge we launched; stray busy pulses are ignored.
  assign xfer_done = pend_q & busy_q & ~spi_busy;
  assign want_byte = (state_q != ST_BOOT) && (state_q != ST_IDLE);
  assign issue     = want_byte & ~pend_q & ~spi_busy;
  assign poll_inc  = (poll_q == '1) ? poll_q : poll_q + 13'd1;

  always_comb begin
    tx_byte = SD_FILL;
    if (state_q == ST_CMD) begin
      case (cnt_q[2:0])
        3'd0:    tx_byte = {2'b01, idx_q};
        3'd1:    tx_byte = arg_q[31:24];
        3'd2:    tx_byte = arg_q[23:16];
        3'd3:    tx_byte = arg_q[15:8];
        3'd4:    tx_byte = arg_q[7:0];
        default: tx_byte = {crc7_q, 1'b1};
      endcase
    end
  end

`ifdef SD_CRC16_CHECK_EN
  logic        crc_clr;
  logic        crc_en;
  logic [15:0] crc16;
  logic [7:0]  crc_hi_q, crc_hi_d;

  assign crc_clr = (state_q == ST_IDLE) & cmd_valid;
  assign crc_en  = (state_q == ST_DATA) & xfer_done;

  sd_crc16 u_crc16 (
    .clk   (CLOCK_50),
    .rst_n (nRESET),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (spi_rx),
    .crc   (crc16)
  );

  always_comb begin
    crc_hi_d = crc_hi_q;
    if ((state_q == ST_CRC) && xfer_done && (cnt_q == 16'd0)) crc_hi_d = spi_rx;
  end

  always_ff @(posedge CLOCK_50 or negedge nRESET) begin
    if (!nRESET) crc_hi_q <= '0;
    else         crc_hi_q <= crc_hi_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    cs_n_d    = cs_n_q;
    r1_d      = r1_q;
    err_d     = err_q;
    idx_d     = idx_q;
    arg_d     = arg_q;
    rd_d      = rd_q;
    crc7_d    = crc7_q;
    poll_d    = poll_q;
    cnt_d     = cnt_q;
    to_tail   = 1'b0;
    spi_start = 1'b0;
    rd_valid  = 1'b0;
    done      = 1'b0;

    if (issue) begin
      spi_start = 1'b1;
      pend_d    = 1'b1;
      if ((state_q == ST_CMD) && (cnt_q < 16'd5)) crc7_d = sd_crc7_byte(crc7_q, tx_byte);
    end
    if (xfer_done) pend_d = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_IDLE;
      ST_IDLE: begin
        if (cmd_valid) begin
          idx_d   = cmd_index;
          arg_d   = cmd_arg;
          rd_d    = cmd_rd_block;
          cs_n_d  = 1'b0;
          err_d   = SD_ERR_OK;
          r1_d    = SD_FILL;
          crc7_d  = '0;
          cnt_d   = '0;
          poll_d  = '0;
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        if (xfer_done) begin
          cnt_d   = '0;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (xfer_done) begin
          if (cnt_q == 16'd5) begin
            poll_d  = '0;
            state_d = ST_R1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_R1: begin
        if (xfer_done) begin
          poll_d = poll_inc;
          if (!spi_rx[7]) begin
            r1_d   = spi_rx;
            poll_d = '0;
            if (rd_q && (spi_rx != 8'h00)) begin
              err_d   = SD_ERR_R1;
              to_tail = 1'b1;
            end else if (rd_q) begin
              state_d = ST_TOKEN;
            end else begin
              to_tail = 1'b1;
            end
          end else if (poll_inc >= 13'(NCR_MAX)) begin
            err_d   = SD_ERR_R1_TIMEOUT;
            to_tail = 1'b1;
          end
        end
      end
      ST_TOKEN: begin
        if (xfer_done) begin
          poll_d = poll_inc;
          if (spi_rx == SD_TOKEN_START) begin
            cnt_d   = '0;
            state_d = ST_DATA;
          end else if (spi_rx[7:4] == 4'h0) begin
            err_d   = SD_ERR_TOKEN;
            to_tail = 1'b1;
          end else if (poll_inc >= 13'(TOKEN_TIMEOUT)) begin
            err_d   = SD_ERR_TOKEN_TIMEOUT;
            to_tail = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (xfer_done) begin
          rd_valid = 1'b1;
          if (cnt_q == 16'(BLOCK_LEN - 1)) begin
            cnt_d   = '0;
            state_d = ST_CRC;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ST_CRC: begin
        if (xfer_done) begin
          if (cnt_q == 16'd0) begin
            cnt_d = 16'd1;
          end else begin
`ifdef SD_CRC16_CHECK_EN
            if ({crc_hi_q, spi_rx} != crc16) err_d = SD_ERR_CRC;
`endif
            to_tail = 1'b1;
          end
        end
      end
      ST_TAIL: begin
        if (xfer_done) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // CS is released before the trailing filler byte is launched.
    if (to_tail) begin
      state_d = ST_TAIL;
      cs_n_d  = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= ST_BOOT;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      r1_q    <= SD_FILL;
      err_q   <= SD_ERR_OK;
      idx_q   <= '0;
      arg_q   <= '0;
      rd_q    <= 1'b0;
      crc7_q  <= '0;
      poll_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      busy_q  <= spi_busy;
      cs_n_q  <= cs_n_d;
      r1_q    <= r1_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      rd_q    <= rd_d;
      crc7_q  <= crc7_d;
      poll_q  <= poll_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign spi_tx    = tx_byte;
  assign spi_cs_n  = cs_n_q;
  assign rd_data   = spi_rx;
  assign r1        = r1_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Self-checking bench for sd_cmd_sequencer: scripted card model plus transaction-level predictor.
module tb_sd_cmd_sequencer;

  localparam int NCR = 8;
  localparam int TOK = 4096;
  localparam int BLK = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic        cmd_rd_block = 1'b0;
  logic        spi_start;
  logic [7:0]  spi_tx;
  logic        spi_busy = 1'b0;
  logic [7:0]  spi_rx = 8'hFF;
  logic        spi_cs_n;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        done;
  logic [7:0]  r1;
  logic [2:0]  err;

  always #5 clk = ~clk;

  sd_cmd_sequencer #(.NCR_MAX(NCR), .TOKEN_TIMEOUT(TOK), .BLOCK_LEN(BLK)) dut (
    .CLOCK_50(clk), .nRESET(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .cmd_rd_block(cmd_rd_block),
    .spi_start(spi_start), .spi_tx(spi_tx), .spi_busy(spi_busy), .spi_rx(spi_rx),
    .spi_cs_n(spi_cs_n), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .r1(r1), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Card reply script: byte n of the transaction returns script[n], FF beyond its end.
  logic [7:0] script[$];
  int         sp = 0;
  logic [7:0] tx_log[$];

  function automatic logic [7:0] sget(input int p);
    return (p < script.size()) ? script[p] : 8'hFF;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (spi_start === 1'b1) begin
        tx_log.push_back(spi_tx);
        @(posedge clk);
        #1 spi_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 spi_busy = 1'b0;
        spi_rx = sget(sp);
        sp++;
      end
    end
  end

  // ---------------- transaction-level model ----------------
  logic [7:0] exp_tx[$];
  bit         exp_cs[$];
  logic [7:0] exp_rd[$];
  logic [7:0] exp_r1;
  logic [2:0] exp_err;
  bit         model_on = 1'b0;
  int         done_cnt = 0;
  int         rd_cnt = 0;

  function automatic logic [6:0] m_crc7(input logic [39:0] bits);
    logic [6:0] c = '0;
    logic       fb;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ bits[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [15:0] m_crc16(input logic [7:0] q[$]);
    logic [15:0] c = '0;
    logic        fb;
    foreach (q[k]) begin
      for (int i = 7; i >= 0; i--) begin
        fb = c[15] ^ q[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic push_tx(input logic [7:0] b, input bit cs);
    exp_tx.push_back(b);
    exp_cs.push_back(cs);
  endtask

  task automatic predict(input logic [5:0] idx, input logic [31:0] arg, input bit rd);
    logic [7:0] cb[6];
    logic [7:0] v;
    int         p;
    bit         got;
    bit         found;
`ifdef SD_CRC16_CHECK_EN
    logic [15:0] rc;
`endif
    exp_tx.delete(); exp_cs.delete(); exp_rd.delete();
    exp_r1 = 8'hFF; exp_err = 3'd0;
    p = 0;
    push_tx(8'hFF, 1'b0); p++;
    cb[0] = {2'b01, idx}; cb[1] = arg[31:24]; cb[2] = arg[23:16];
    cb[3] = arg[15:8];    cb[4] = arg[7:0];
    cb[5] = {m_crc7({cb[0], cb[1], cb[2], cb[3], cb[4]}), 1'b1};
    for (int i = 0; i < 6; i++) begin push_tx(cb[i], 1'b0); p++; end
    got = 1'b0;
    for (int n = 0; n < NCR && !got; n++) begin
      push_tx(8'hFF, 1'b0); v = sget(p); p++;
      if (!v[7]) begin got = 1'b1; exp_r1 = v; end
    end
    if (!got) exp_err = 3'd1;
    else if (rd && exp_r1 != 8'h00) exp_err = 3'd2;
    else if (rd) begin
      found = 1'b0;
      for (int n = 0; n < TOK && !found && exp_err == 3'd0; n++) begin
        push_tx(8'hFF, 1'b0); v = sget(p); p++;
        if (v == 8'hFE) found = 1'b1;
        else if (v[7:4] == 4'h0) exp_err = 3'd4;
      end
      if (!found && exp_err == 3'd0) exp_err = 3'd3;
      if (found) begin
        for (int n = 0; n < BLK; n++) begin
          push_tx(8'hFF, 1'b0); exp_rd.push_back(sget(p)); p++;
        end
        push_tx(8'hFF, 1'b0); push_tx(8'hFF, 1'b0);
`ifdef SD_CRC16_CHECK_EN
        rc = {sget(p), sget(p + 1)};
        if (rc != m_crc16(exp_rd)) exp_err = 3'd5;
`endif
      end
    end
    push_tx(8'hFF, 1'b1);
  endtask

  // Compare process: every launched byte, every data strobe and every done pulse.
  always @(negedge clk) begin
    if (model_on) begin
      if (spi_start === 1'b1) begin
        if (exp_tx.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_start: spi_start with tx=%0h, expected no transfer", spi_tx);
        end else begin
          check("spi_tx", {24'd0, spi_tx}, {24'd0, exp_tx.pop_front()});
          check("cs_n_at_start", {31'd0, spi_cs_n}, {31'd0, exp_cs.pop_front()});
        end
      end
      if (rd_valid === 1'b1) begin
        rd_cnt++;
        if (exp_rd.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL extra_rd_valid: rd_data=%0h, expected no data strobe", rd_data);
        end else begin
          check("rd_data", {24'd0, rd_data}, {24'd0, exp_rd.pop_front()});
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("r1_at_done", {24'd0, r1}, {24'd0, exp_r1});
        check("err_at_done", {29'd0, err}, {29'd0, exp_err});
        check("tx_left_at_done", exp_tx.size(), 0);
        check("rd_left_at_done", exp_rd.size(), 0);
      end
    end
  end

  task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit rd,
                           input int hold_valid);
    sp = 0; tx_log.delete(); done_cnt = 0; rd_cnt = 0;
    predict(idx, arg, rd);
    model_on = 1'b1;
    @(negedge clk);
    check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_index = idx; cmd_arg = arg; cmd_rd_block = rd;
    @(posedge clk);
    #1 cmd_arg = ~arg;
    check("cmd_ready_after_accept", {31'd0, cmd_ready}, 32'd0);
    if (hold_valid > 0) repeat (hold_valid) @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit rd,
                         input int hold_valid);
    start_cmd(idx, arg, rd, hold_valid);
    for (int i = 0; i < 20000 && done_cnt == 0; i++) @(negedge clk);
    if (done_cnt == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: no done after 20000 cycles, expected one");
    end
    repeat (5) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("cs_n_after", {31'd0, spi_cs_n}, 32'd1);
    check("r1_hold", {24'd0, r1}, {24'd0, exp_r1});
    check("err_hold", {29'd0, err}, {29'd0, exp_err});
    model_on = 1'b0;
  endtask

  task automatic fill_script(input int n, input logic [7:0] b);
    for (int i = 0; i < n; i++) script.push_back(b);
  endtask

  task automatic block_script(input logic [7:0] tok[$], input logic [15:0] crc_xor);
    logic [7:0]  blk[$];
    logic [15:0] c;
    script.delete();
    fill_script(7, 8'hFF);
    script.push_back(8'h00);
    foreach (tok[i]) script.push_back(tok[i]);
    for (int i = 0; i < BLK; i++) begin
      blk.push_back(8'(i));
      script.push_back(8'(i));
    end
    c = m_crc16(blk) ^ crc_xor;
    script.push_back(c[15:8]);
    script.push_back(c[7:0]);
  endtask

  logic [7:0] lit_cmd0[7] = '{8'hFF, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
  logic [7:0] lit_cmd8[6] = '{8'h48, 8'h00, 8'h00, 8'h01, 8'hAA, 8'h87};

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_spi_start", {31'd0, spi_start}, 32'd0);
    check("rst_spi_tx", {24'd0, spi_tx}, 32'hFF);
    check("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_r1", {24'd0, r1}, 32'hFF);
    check("rst_err", {29'd0, err}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_first_cycle", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check("cmd_ready_second_cycle", {31'd0, cmd_ready}, 32'd1);

    // CMD0: card answers FF then 01
    script.delete(); fill_script(8, 8'hFF); script.push_back(8'h01);
    run_cmd(6'd0, 32'h0, 1'b0, 0);
    for (int i = 0; i < 7; i++) check("cmd0_byte", {24'd0, tx_log[i]}, {24'd0, lit_cmd0[i]});
    check("cmd0_nbytes", tx_log.size(), 10);
    check("cmd0_r1", {24'd0, r1}, 32'h01);

    // CMD8 with cmd_valid held high past acceptance
    script.delete(); fill_script(7, 8'hFF); script.push_back(8'h01);
    run_cmd(6'd8, 32'h0000_01AA, 1'b0, 20);
    for (int i = 0; i < 6; i++) check("cmd8_byte", {24'd0, tx_log[i + 1]}, {24'd0, lit_cmd8[i]});

    // R1 timeout: card silent
    script.delete(); fill_script(7, 8'hFF);
    run_cmd(6'd0, 32'h0, 1'b0, 0);
    check("r1to_nbytes", tx_log.size(), 1 + 6 + NCR + 1);
    check("r1to_err", {29'd0, err}, 32'd1);
    check("r1to_rd_cnt", rd_cnt, 0);

    // CMD17 block read, good CRC
    block_script('{8'hFF, 8'hFF, 8'hFF, 8'hFE}, 16'h0000);
    run_cmd(6'd17, 32'h0000_0200, 1'b1, 0);
    check("blk_rd_cnt", rd_cnt, BLK);
    check("blk_err", {29'd0, err}, 32'd0);

    // CMD17 with an ignored token byte and a corrupted CRC
    block_script('{8'hFF, 8'h3C, 8'hFE}, 16'h0001);
    run_cmd(6'd17, 32'h0, 1'b1, 0);
    check("badcrc_rd_cnt", rd_cnt, BLK);
`ifdef SD_CRC16_CHECK_EN
    check("badcrc_err", {29'd0, err}, 32'd5);
`else
    check("badcrc_err", {29'd0, err}, 32'd0);
`endif

    // Error token
    script.delete(); fill_script(7, 8'hFF); script.push_back(8'h00); script.push_back(8'h05);
    run_cmd(6'd17, 32'h0, 1'b1, 0);
    check("errtok_err", {29'd0, err}, 32'd4);
    check("errtok_rd_cnt", rd_cnt, 0);

    // Nonzero R1 aborts the read before token polling
    script.delete(); fill_script(7, 8'hFF); script.push_back(8'h04);
    run_cmd(6'd17, 32'h0, 1'b1, 0);
    check("r1bad_err", {29'd0, err}, 32'd2);
    check("r1bad_r1", {24'd0, r1}, 32'h04);
    check("r1bad_nbytes", tx_log.size(), 9);

    // Reset in the middle of DATA
    block_script('{8'hFE}, 16'h0000);
    start_cmd(6'd17, 32'h0, 1'b1, 0);
    for (int i = 0; i < 20000 && rd_cnt < 100; i++) @(negedge clk);
    check("mid_rd_reached", {31'd0, rd_cnt >= 100}, 32'd1);
    model_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    check("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_done", {31'd0, done}, 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("postrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("postrst_r1", {24'd0, r1}, 32'hFF);
    check("postrst_err", {29'd0, err}, 32'd0);

    // Normal CMD0 after the aborted read
    script.delete(); fill_script(7, 8'hFF); script.push_back(8'h01);
    run_cmd(6'd0, 32'h0, 1'b0, 0);
    for (int i = 0; i < 7; i++) check("cmd0b_byte", {24'd0, tx_log[i]}, {24'd0, lit_cmd0[i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
